vpg_mode_ctrl: RTL and testbench
================================

VPG_MODE_CTRL -- requirements
Module: vpg_mode_ctrl

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 16: cycles gen_reset_n is held low per mode switch.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1024: post-load wait before release (no-PLL build).
REQ-003 SHALL have parameter FRAME_TIMEOUT, default 4194304: maximum cycles spent waiting for a frame boundary.
REQ-004 SHALL have one clock and a synchronous, active-low reset; ports: clk in 1, rising-edge clock; reset_n in 1, synchronous active-low reset.
REQ-005 SHALL have ports: mode_sel in 3, requested mode; mode_req in 1, request strobe; mode_ack out 1, one-cycle accept/complete pulse; mode_busy out 1, switch in progress; mode_err out 1, one-cycle pulse on invalid mode.
REQ-006 SHALL have ports: vga_vs in 1, generator vsync (active low); gen_reset_n out 1, generator reset; cur_mode out 3, active mode.
REQ-007 SHALL have outputs of 12 bits each: h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end, v_active_14, v_active_24, v_active_34 (generator timing).
REQ-008 SHALL have, only with VPG_PLL_HANDSHAKE_EN: pll_req out 1, pll_sel out 3, pll_done in 1.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT_FRAME, BLANK, LOAD, SETTLE, RUN.
REQ-010 IDLE: after reset, SHALL auto-load mode 0 via BLANK with no frame wait.
REQ-011 RUN, mode_req=1, mode_sel valid (0..3): SHALL latch mode_sel, raise mode_busy next cycle, go to WAIT_FRAME.
REQ-012 mode_sel 4..7: SHALL pulse mode_err, stay in RUN, and leave outputs unchanged.
REQ-013 mode_req while mode_busy=1 SHALL be ignored (no ack, no err).
REQ-014 mode_req with mode_sel equal to cur_mode SHALL pulse mode_ack the next cycle and perform no switch.
REQ-015 WAIT_FRAME: SHALL exit on a vga_vs falling edge (registered 2-stage sample) or on timeout counter == FRAME_TIMEOUT-1, whichever is first.
REQ-016 BLANK: gen_reset_n SHALL be 0 for exactly BLANK_CYCLES cycles.
REQ-017 LOAD: all timing outputs SHALL be updated in one cycle from the mode table, with gen_reset_n still 0.
REQ-018 Timing outputs SHALL change only in LOAD.
REQ-019 SETTLE: gen_reset_n SHALL be 0; exit after SETTLE_CYCLES cycles.
REQ-020 On SETTLE exit: gen_reset_n=1, cur_mode=latched mode, mode_ack pulses 1 cycle, mode_busy=0, state RUN.
REQ-021 Counters SHALL be 23-bit, shall not wrap, and shall clear on every state entry.

Reset
REQ-022 reset_n=0 sampled at a clk edge SHALL set: state IDLE, gen_reset_n=0, mode_busy=0, mode_ack=0, mode_err=0, cur_mode=0, pll_req=0, timing outputs=mode 0 values.
REQ-023 Reset asserted mid-switch SHALL abandon the switch; no ack is issued for it.

Configuration
REQ-024 With macro VPG_PLL_HANDSHAKE_EN defined, SETTLE SHALL assert pll_req (level) with pll_sel=latched mode, exit on pll_done=1, drop pll_req the same cycle, and ignore SETTLE_CYCLES.
REQ-025 Without VPG_PLL_HANDSHAKE_EN, the PLL ports SHALL be absent and SETTLE SHALL be the fixed count.

Structure
REQ-026 Package vpg_pkg SHALL hold the FSM state enum, the timing-record struct (11 x 12-bit), the 4-entry mode table and the mode index width.
REQ-027 Mode table mode 0 (640x480) SHALL be: 799,95,141,781,524,1,34,514,154,274,394; modes 1..3 SHALL be 720p, 1080p and 1024x768 per the team's timing sheet.
REQ-028 Sub-module vpg_mode_rom SHALL be used: combinational index-to-record lookup.

Verification
REQ-029 Reset release -> within BLANK_CYCLES+SETTLE_CYCLES+3 cycles gen_reset_n=1, cur_mode=0, h_total=799, v_end=514.
REQ-030 In RUN, mode_req with mode_sel=2, vga_vs falling 500 cycles later -> gen_reset_n low exactly 16+1+1024 cycles, then mode_ack one pulse, cur_mode=2.
REQ-031 mode_sel=5 -> mode_err one pulse; cur_mode and h_total unchanged; mode_busy stays 0.
REQ-032 vga_vs held high -> BLANK entered after exactly FRAME_TIMEOUT cycles in WAIT_FRAME.
REQ-033 Second mode_req during busy -> ignored; reset asserted in SETTLE -> no ack, mode 0 values restored.
REQ-034 PLL build: pll_done delayed 300 cycles -> pll_req high for 300 cycles, then ack; pll_sel equals requested mode.

Source files
------------

// File: rtl/vpg_pkg.sv
// vpg_pkg: shared FSM states, timing record and mode table for the video pattern generator
package vpg_pkg;

    localparam int MODE_W  = 2;
    localparam int N_MODES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        BLANK,
        LOAD,
        SETTLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
        logic [11:0] v_active_14;
        logic [11:0] v_active_24;
        logic [11:0] v_active_34;
    } timing_t;

    // 0: 640x480, 1: 1280x720, 2: 1920x1080, 3: 1024x768
    localparam timing_t [N_MODES-1:0] MODE_TABLE = '{
        0: '{12'd799,  12'd95,  12'd141, 12'd781,  12'd524,  12'd1, 12'd34, 12'd514,  12'd154, 12'd274, 12'd394},
        1: '{12'd1649, 12'd39,  12'd257, 12'd1537, 12'd749,  12'd4, 12'd24, 12'd744,  12'd204, 12'd384, 12'd564},
        2: '{12'd2199, 12'd43,  12'd189, 12'd2109, 12'd1124, 12'd4, 12'd40, 12'd1120, 12'd310, 12'd580, 12'd850},
        3: '{12'd1343, 12'd135, 12'd293, 12'd1317, 12'd805,  12'd5, 12'd34, 12'd802,  12'd226, 12'd418, 12'd610}
    };

endpackage

// File: rtl/vpg_mode_rom.sv
// vpg_mode_rom: combinational mode index to timing record lookup
module vpg_mode_rom
    import vpg_pkg::*;
(
    input  logic [MODE_W-1:0] idx,
    output timing_t           rec
);

    assign rec = MODE_TABLE[idx];

endmodule

// File: rtl/vpg_mode_ctrl.sv
// vpg_mode_ctrl: mode switch sequencer for the video pattern generator (VPG_PLL_HANDSHAKE_EN adds a PLL handshake in SETTLE)
module vpg_mode_ctrl
    import vpg_pkg::*;
#(
    parameter int BLANK_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int FRAME_TIMEOUT = 4194304
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  mode_sel,
    input  logic        mode_req,
    output logic        mode_ack,
    output logic        mode_busy,
    output logic        mode_err,
    input  logic        vga_vs,
    output logic        gen_reset_n,
    output logic [2:0]  cur_mode,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34
`ifdef VPG_PLL_HANDSHAKE_EN
    ,
    output logic        pll_req,
    output logic [2:0]  pll_sel,
    input  logic        pll_done
`endif
);

    localparam logic [22:0] BLANK_END = 23'(BLANK_CYCLES - 1);
    localparam logic [22:0] FT_END    = 23'(FRAME_TIMEOUT - 1);

    state_t              state, state_next;
    logic [22:0]         cnt;
    logic [MODE_W-1:0]   tgt;
    logic [2:0]          cur;
    logic                busy, ack, err;
    logic                vs_s1, vs_s2;
    timing_t             tim, rom_rec;
    logic                req_ok, invalid, same, accept, vs_fall, settle_done;

    vpg_mode_rom u_rom (
        .idx (tgt),
        .rec (rom_rec)
    );

    assign req_ok  = state == RUN && mode_req && !busy;
    assign invalid = req_ok && mode_sel[2];
    assign same    = req_ok && !mode_sel[2] && mode_sel == cur;
    assign accept  = req_ok && !mode_sel[2] && mode_sel != cur;
    assign vs_fall = vs_s2 && !vs_s1;

`ifdef VPG_PLL_HANDSHAKE_EN
    assign settle_done = pll_done;
    assign pll_req     = state == SETTLE && !pll_done;
    assign pll_sel     = {1'b0, tgt};
`else
    localparam logic [22:0] SETTLE_END = 23'(SETTLE_CYCLES - 1);
    assign settle_done = cnt == SETTLE_END;
`endif

    // next-state selection; the generator keeps running while waiting for the frame boundary
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = BLANK;
            RUN:        state_next = accept ? WAIT_FRAME : RUN;
            WAIT_FRAME: state_next = (vs_fall || cnt == FT_END) ? BLANK : WAIT_FRAME;
            BLANK:      state_next = cnt == BLANK_END ? LOAD : BLANK;
            LOAD:       state_next = SETTLE;
            SETTLE:     state_next = settle_done ? RUN : SETTLE;
            default:    state_next = IDLE;
        endcase
    end

    // state register and saturating per-state cycle counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= state_next != state ? '0 : (&cnt ? cnt : cnt + 23'd1);
        end
    end

    // request handling, timing load and completion; auto-load after reset completes silently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tgt  <= '0;
            cur  <= '0;
            busy <= 1'b0;
            ack  <= 1'b0;
            err  <= 1'b0;
            tim  <= MODE_TABLE[0];
        end else begin
            if (accept)
                tgt <= mode_sel[MODE_W-1:0];
            if (state == LOAD)
                tim <= rom_rec;
            if (state == SETTLE && settle_done)
                cur <= {1'b0, tgt};
            busy <= accept ? 1'b1 : (state == SETTLE && settle_done) ? 1'b0 : busy;
            ack  <= same || (state == SETTLE && settle_done && busy);
            err  <= invalid;
        end
    end

    // two-stage vsync sample; idles high so reset cannot fake a falling edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
        end else begin
            vs_s1 <= vga_vs;
            vs_s2 <= vs_s1;
        end
    end

    assign gen_reset_n = state == RUN || state == WAIT_FRAME;
    assign mode_ack    = ack;
    assign mode_busy   = busy;
    assign mode_err    = err;
    assign cur_mode    = cur;
    assign h_total     = tim.h_total;
    assign h_sync      = tim.h_sync;
    assign h_start     = tim.h_start;
    assign h_end       = tim.h_end;
    assign v_total     = tim.v_total;
    assign v_sync      = tim.v_sync;
    assign v_start     = tim.v_start;
    assign v_end       = tim.v_end;
    assign v_active_14 = tim.v_active_14;
    assign v_active_24 = tim.v_active_24;
    assign v_active_34 = tim.v_active_34;

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// tb_vpg_mode_ctrl: randomized mode-switch bench with a transaction-level reference model
module tb_vpg_mode_ctrl;

    localparam int BLK = 16;
    localparam int STL = 1024;
    localparam int FT  = 700;
`ifdef VPG_PLL_HANDSHAKE_EN
    localparam int SETTLE_LEN = 301;
`else
    localparam int SETTLE_LEN = STL;
`endif

    logic        clk = 0, reset_n = 0, mode_req = 0, vga_vs = 1;
    logic [2:0]  mode_sel = 0;
    logic        mode_ack, mode_busy, mode_err, gen_reset_n;
    logic [2:0]  cur_mode;
    logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
    logic [11:0] v_active_14, v_active_24, v_active_34;
    int          n_chk = 0, n_fail = 0, exp_mode = 0;
    logic [11:0] tbl [4][11];

`ifdef VPG_PLL_HANDSHAKE_EN
    logic        pll_req, pll_done = 0;
    logic [2:0]  pll_sel;
    int          pcnt = 0;
    always @(posedge clk) begin
        pll_done <= pll_req && pcnt == 299;
        pcnt     <= pll_req ? pcnt + 1 : 0;
    end
`endif

    vpg_mode_ctrl #(.BLANK_CYCLES(BLK), .SETTLE_CYCLES(STL), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .reset_n(reset_n), .mode_sel(mode_sel), .mode_req(mode_req),
        .mode_ack(mode_ack), .mode_busy(mode_busy), .mode_err(mode_err),
        .vga_vs(vga_vs), .gen_reset_n(gen_reset_n), .cur_mode(cur_mode),
        .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
        .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
        .v_active_14(v_active_14), .v_active_24(v_active_24), .v_active_34(v_active_34)
`ifdef VPG_PLL_HANDSHAKE_EN
        , .pll_req(pll_req), .pll_sel(pll_sel), .pll_done(pll_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [131:0] dut_tim();
        return {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end,
                v_active_14, v_active_24, v_active_34};
    endfunction

    function automatic logic [131:0] exp_tim(input int m);
        logic [131:0] r = '0;
        for (int i = 0; i < 11; i++) r = {r[119:0], tbl[m][i]};
        return r;
    endfunction

    // release reset: one idle cycle, blank, load and settle before the generator runs
    task automatic pwr_up(input string tag);
        int k = 0, acks = 0, busys = 0;
        reset_n = 1;
        while (!gen_reset_n && k < 3000) begin
            acks += mode_ack;
            busys += mode_busy;
            tick();
            k++;
        end
        check({tag, " release cycles"}, k, 2 + BLK + SETTLE_LEN);
        check({tag, " no ack"}, acks + mode_ack, 0);
        check({tag, " no busy"}, busys + mode_busy, 0);
        check({tag, " cur_mode"}, cur_mode, 0);
        check({tag, " h_total"}, h_total, 799);
        check({tag, " v_end"}, v_end, 514);
        check({tag, " timing"}, dut_tim(), exp_tim(0));
        exp_mode = 0;
    endtask

    task automatic req(input int m, input int d, input bit extra);
        int wf = 0, lo = 0, acks = 0, errs = 0, pr = 0, exp_wf;
        mode_sel = 3'(m);
        mode_req = 1;
        tick();
        mode_req = 0;
        if (m > 3) begin
            check("err pulse", mode_err, 1);
            check("err no ack", mode_ack, 0);
            check("err busy", mode_busy, 0);
            tick();
            check("err one cycle", mode_err, 0);
            check("err busy after", mode_busy, 0);
            check("err cur_mode", cur_mode, exp_mode);
            check("err timing", dut_tim(), exp_tim(exp_mode));
            return;
        end
        if (m == exp_mode) begin
            check("same ack", mode_ack, 1);
            check("same busy", mode_busy, 0);
            check("same gen", gen_reset_n, 1);
            tick();
            check("same ack one cycle", mode_ack, 0);
            check("same cur_mode", cur_mode, exp_mode);
            return;
        end
        check("busy raised", mode_busy, 1);
        check("gen runs in wait", gen_reset_n, 1);
        exp_wf = (d + 2 < FT) ? d + 2 : FT;
        while (gen_reset_n && wf < FT + 10) begin
            if (wf == d) vga_vs = 0;
            if (extra && wf == 3) begin
                mode_sel = 3'($urandom_range(0, 7));
                mode_req = 1;
            end
            if (extra && wf == 4) mode_req = 0;
            acks += mode_ack;
            errs += mode_err;
            tick();
            wf++;
        end
        mode_req = 0;
        vga_vs = 1;
        check("wait_frame cycles", wf, exp_wf);
        while (!gen_reset_n && lo < 3000) begin
            if (lo == BLK - 1) check("timing held in blank", dut_tim(), exp_tim(exp_mode));
            if (lo == BLK + 1) begin
                check("timing loaded", dut_tim(), exp_tim(m));
                check("cur_mode held", cur_mode, exp_mode);
`ifdef VPG_PLL_HANDSHAKE_EN
                check("pll_sel", pll_sel, m);
`endif
            end
`ifdef VPG_PLL_HANDSHAKE_EN
            pr += pll_req;
`endif
            acks += mode_ack;
            errs += mode_err;
            tick();
            lo++;
        end
`ifdef VPG_PLL_HANDSHAKE_EN
        check("pll_req cycles", pr, 300);
`endif
        check("gen low cycles", lo, BLK + 1 + SETTLE_LEN);
        check("no early ack", acks, 0);
        check("no err in switch", errs, 0);
        check("done ack", mode_ack, 1);
        check("done busy", mode_busy, 0);
        check("done cur_mode", cur_mode, m);
        check("done timing", dut_tim(), exp_tim(m));
        exp_mode = m;
        tick();
        check("done ack one cycle", mode_ack, 0);
    endtask

    // reset in the middle of SETTLE abandons the switch and restores mode 0
    task automatic abort_switch();
        int k = 0;
        int m = (exp_mode == 3) ? 1 : 3;
        mode_sel = 3'(m);
        mode_req = 1;
        tick();
        mode_req = 0;
        vga_vs = 0;
        while (gen_reset_n && k < FT + 10) begin
            tick();
            k++;
        end
        vga_vs = 1;
        repeat (BLK + 100) tick();
        reset_n = 0;
        tick();
        tick();
        check("abort gen", gen_reset_n, 0);
        check("abort busy", mode_busy, 0);
        check("abort ack", mode_ack, 0);
        check("abort cur_mode", cur_mode, 0);
        check("abort timing", dut_tim(), exp_tim(0));
        pwr_up("abort");
    endtask

    initial begin
        tbl = '{
            '{12'd799,  12'd95,  12'd141, 12'd781,  12'd524,  12'd1, 12'd34, 12'd514,  12'd154, 12'd274, 12'd394},
            '{12'd1649, 12'd39,  12'd257, 12'd1537, 12'd749,  12'd4, 12'd24, 12'd744,  12'd204, 12'd384, 12'd564},
            '{12'd2199, 12'd43,  12'd189, 12'd2109, 12'd1124, 12'd4, 12'd40, 12'd1120, 12'd310, 12'd580, 12'd850},
            '{12'd1343, 12'd135, 12'd293, 12'd1317, 12'd805,  12'd5, 12'd34, 12'd802,  12'd226, 12'd418, 12'd610}
        };
        reset_n = 0;
        repeat (3) tick();
        check("rst gen", gen_reset_n, 0);
        check("rst busy", mode_busy, 0);
        check("rst ack", mode_ack, 0);
        check("rst err", mode_err, 0);
        check("rst cur_mode", cur_mode, 0);
        check("rst timing", dut_tim(), exp_tim(0));
`ifdef VPG_PLL_HANDSHAKE_EN
        check("rst pll_req", pll_req, 0);
`endif
        pwr_up("por");
        req(2, 500, 0);
        req(5, 0, 0);
        req(2, 0, 0);
        req(1, FT + 50, 0);
        req(3, 100, 1);
        abort_switch();
        repeat (10) req($urandom_range(0, 7), $urandom_range(0, FT + 100), 1'($urandom_range(0, 1)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
